// File: rtl/sys_defs.sv
// Shared bus/memory types and arbiter enums used by the memory-side controllers.
package sys_defs;

    localparam int NUM_MEM_TAGS = 15;
    localparam int DATA_SIZE    = 64;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'h0,
        ARB_HOLD_I = 2'h1,
        ARB_HOLD_D = 2'h2
    } ARB_STATE;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } ARB_OWNER;

endpackage

// File: rtl/mem_tag_scoreboard.sv
// Tracks which requester owns each outstanding memory load tag; tag 0 is never tracked.
module mem_tag_scoreboard
    import sys_defs::*;
#(
    parameter int  NUM_TAGS = NUM_MEM_TAGS,
    localparam int TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set_en,
    input  logic [TAG_W-1:0] set_tag,
    input  ARB_OWNER         set_owner,
    input  logic [TAG_W-1:0] ret_tag,
    output logic             hit,
    output ARB_OWNER         hit_owner,
    output logic             overwrite,
    output logic [TAG_W:0]   outstanding
);

    localparam int DEPTH = 1 << TAG_W;

    logic [DEPTH-1:0] valid;
    ARB_OWNER         owner [DEPTH];

    assign hit       = (ret_tag != '0) && valid[ret_tag];
    assign hit_owner = owner[ret_tag];
    // a tag being returned and re-issued in the same cycle is a legal reuse
    assign overwrite = set_en && valid[set_tag] && !(hit && (ret_tag == set_tag));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else begin
            if (hit)
                valid[ret_tag] <= 1'b0;
            if (set_en && (set_tag != '0))
                valid[set_tag] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (set_en && (set_tag != '0))
            owner[set_tag] <= set_owner;
    end

    always_comb begin
        outstanding = '0;
        for (int i = 1; i < DEPTH; i++)
            outstanding = outstanding + (TAG_W+1)'(valid[i]);
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the processor-to-memory bus between icache and dcache and routes
// returning load data back to whichever side issued the tag.
module mem_bus_arbiter
    import sys_defs::*;
#(
    parameter int  NUM_TAGS     = NUM_MEM_TAGS,
    parameter int  STARVE_LIMIT = 4,
    localparam int TAG_W        = $clog2(NUM_TAGS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  BUS_COMMAND           icache_command,
    input  logic [31:0]          icache_addr,
    input  BUS_COMMAND           dcache_command,
    input  logic [31:0]          dcache_addr,
    input  logic [DATA_SIZE-1:0] dcache_wdata,
    input  MEM_SIZE              dcache_size,
    input  logic [TAG_W-1:0]     mem2proc_response,
    input  logic [DATA_SIZE-1:0] mem2proc_data,
    input  logic [TAG_W-1:0]     mem2proc_tag,
    output BUS_COMMAND           proc2mem_command,
    output logic [31:0]          proc2mem_addr,
    output logic [DATA_SIZE-1:0] proc2mem_data,
    output MEM_SIZE              proc2mem_size,
    output logic [TAG_W-1:0]     icache_response,
    output logic [DATA_SIZE-1:0] icache_rdata,
    output logic [TAG_W-1:0]     icache_tag,
    output logic [TAG_W-1:0]     dcache_response,
    output logic [DATA_SIZE-1:0] dcache_rdata,
    output logic [TAG_W-1:0]     dcache_tag,
    output logic [TAG_W:0]       outstanding,
    output logic                 spurious_tag
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    ARB_STATE   state, state_next;
    logic [SW-1:0] starve_cnt;
    logic       grant_i, grant_d, accepted, icache_act, dcache_act;
    logic       set_en, hit, overwrite;
    ARB_OWNER   hit_owner;
    BUS_COMMAND granted_cmd;

    assign icache_act  = (icache_command != BUS_NONE);
    assign dcache_act  = (dcache_command != BUS_NONE);
    assign accepted    = (mem2proc_response != '0);
    assign granted_cmd = grant_i ? icache_command : dcache_command;
    assign set_en      = reset && (grant_i || grant_d) && accepted && (granted_cmd == BUS_LOAD);

    // a held requester that drops its command falls through to the idle rules
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == ARB_HOLD_I && icache_act)
            grant_i = 1'b1;
        else if (state == ARB_HOLD_D && dcache_act)
            grant_d = 1'b1;
        else if (icache_act && dcache_act) begin
            if (starve_cnt == SW'(STARVE_LIMIT))
                grant_i = 1'b1;
            else
                grant_d = 1'b1;
        end else if (dcache_act)
            grant_d = 1'b1;
        else if (icache_act)
            grant_i = 1'b1;
    end

    always_comb begin
        state_next = ARB_IDLE;
        if (grant_i && !accepted)
            state_next = ARB_HOLD_I;
        else if (grant_d && !accepted)
            state_next = ARB_HOLD_D;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= ARB_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            starve_cnt <= '0;
        else if (!icache_act || (grant_i && accepted))
            starve_cnt <= '0;
        else if (grant_d && accepted && (starve_cnt != SW'(STARVE_LIMIT)))
            starve_cnt <= starve_cnt + SW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            spurious_tag <= 1'b0;
        else if (((mem2proc_tag != '0) && !hit) || overwrite)
            spurious_tag <= 1'b1;
    end

    // all bus-facing outputs are forced quiet while reset is held
    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        proc2mem_size    = BYTE;
        icache_response  = '0;
        dcache_response  = '0;
        icache_rdata     = '0;
        icache_tag       = '0;
        dcache_rdata     = '0;
        dcache_tag       = '0;
        if (reset) begin
            if (grant_i) begin
                proc2mem_command = icache_command;
                proc2mem_addr    = icache_addr;
                proc2mem_size    = DOUBLE;
                icache_response  = mem2proc_response;
            end else if (grant_d) begin
                proc2mem_command = dcache_command;
                proc2mem_addr    = dcache_addr;
                proc2mem_data    = dcache_wdata;
                proc2mem_size    = dcache_size;
                dcache_response  = mem2proc_response;
            end
            if (hit) begin
                if (hit_owner == OWN_I) begin
                    icache_rdata = mem2proc_data;
                    icache_tag   = mem2proc_tag;
                end else begin
                    dcache_rdata = mem2proc_data;
                    dcache_tag   = mem2proc_tag;
                end
            end
        end
    end

    mem_tag_scoreboard #(.NUM_TAGS(NUM_TAGS)) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .set_en      (set_en),
        .set_tag     (mem2proc_response),
        .set_owner   (grant_i ? OWN_I : OWN_D),
        .ret_tag     (mem2proc_tag),
        .hit         (hit),
        .hit_owner   (hit_owner),
        .overwrite   (overwrite),
        .outstanding (outstanding)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Vector-table bench for mem_bus_arbiter with an expected-output queue.
module tb_mem_bus_arbiter;
    import sys_defs::*;

    localparam int TW = 4;

    typedef struct packed {
        logic [1:0]  ic_cmd;
        logic [31:0] ic_addr;
        logic [1:0]  dc_cmd;
        logic [31:0] dc_addr;
        logic [63:0] wdata;
        logic [1:0]  dsize;
        logic [3:0]  resp;
        logic [63:0] mdata;
        logic [3:0]  mtag;
    } stim_t;

    typedef struct packed {
        logic [1:0]  st;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
        logic [3:0]  iresp;
        logic [3:0]  dresp;
        logic [63:0] irdata;
        logic [3:0]  itag;
        logic [63:0] drdata;
        logic [3:0]  dtag;
        logic [4:0]  outst;
        logic        spur;
    } out_t;

    typedef struct {
        stim_t stim;
        out_t  exp;
    } vec_t;

    localparam logic [1:0] N = 2'd0, LD = 2'd1, ST = 2'd2;
    localparam logic [1:0] S_ID = 2'd0, S_HD = 2'd2;

    logic             clock = 1'b0;
    logic             reset;
    BUS_COMMAND       icache_command, dcache_command, proc2mem_command;
    logic [31:0]      icache_addr, dcache_addr, proc2mem_addr;
    logic [63:0]      dcache_wdata, mem2proc_data, proc2mem_data;
    MEM_SIZE          dcache_size, proc2mem_size;
    logic [TW-1:0]    mem2proc_response, mem2proc_tag;
    logic [TW-1:0]    icache_response, icache_tag, dcache_response, dcache_tag;
    logic [63:0]      icache_rdata, dcache_rdata;
    logic [TW:0]      outstanding;
    logic             spurious_tag;

    int   checks = 0;
    int   failures = 0;
    out_t exp_q[$];
    vec_t tbl[21];

    always #5 clock = ~clock;

    mem_bus_arbiter #(.NUM_TAGS(15), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .icache_command(icache_command), .icache_addr(icache_addr),
        .dcache_command(dcache_command), .dcache_addr(dcache_addr),
        .dcache_wdata(dcache_wdata), .dcache_size(dcache_size),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
        .icache_response(icache_response), .icache_rdata(icache_rdata),
        .icache_tag(icache_tag), .dcache_response(dcache_response),
        .dcache_rdata(dcache_rdata), .dcache_tag(dcache_tag),
        .outstanding(outstanding), .spurious_tag(spurious_tag)
    );

    function automatic stim_t mk_in(logic [1:0] ic, logic [31:0] ia, logic [1:0] dc,
                                    logic [31:0] da, logic [63:0] wd, logic [1:0] ds,
                                    logic [3:0] rsp, logic [63:0] md, logic [3:0] mt);
        return '{ic, ia, dc, da, wd, ds, rsp, md, mt};
    endfunction

    function automatic out_t mk_out(logic [1:0] st, logic [1:0] cmd, logic [31:0] a,
                                    logic [63:0] d, logic [1:0] sz, logic [3:0] ir,
                                    logic [3:0] dr, logic [63:0] ird, logic [3:0] it,
                                    logic [63:0] drd, logic [3:0] dt, logic [4:0] os,
                                    logic sp);
        return '{st, cmd, a, d, sz, ir, dr, ird, it, drd, dt, os, sp};
    endfunction

    function automatic out_t actual();
        return '{dut.state, proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
                 icache_response, dcache_response, icache_rdata, icache_tag,
                 dcache_rdata, dcache_tag, outstanding, spurious_tag};
    endfunction

    task automatic drive(input stim_t s);
        icache_command    = BUS_COMMAND'(s.ic_cmd);
        icache_addr       = s.ic_addr;
        dcache_command    = BUS_COMMAND'(s.dc_cmd);
        dcache_addr       = s.dc_addr;
        dcache_wdata      = s.wdata;
        dcache_size       = MEM_SIZE'(s.dsize);
        mem2proc_response = s.resp;
        mem2proc_data     = s.mdata;
        mem2proc_tag      = s.mtag;
    endtask

    task automatic apply(input vec_t v, input string name);
        out_t e, a;
        @(posedge clock);
        #1;
        drive(v.stim);
        exp_q.push_back(v.exp);
        @(negedge clock);
        a = actual();
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: no expected entry queued", name);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got %h required %h", name, a, e);
            end
        end
    endtask

    initial begin
        out_t a;
        reset = 1'b0;
        drive(mk_in(N, 0, N, 0, 0, 0, 0, 0, 0));

        // single icache load and its return two cycles later
        tbl[0]  = '{mk_in(N, 0, N, 0, 0, 0, 0, 0, 0),           mk_out(S_ID, N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{mk_in(LD, 'h100, N, 0, 0, 0, 3, 0, 0),       mk_out(S_ID, LD, 'h100, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{mk_in(N, 0, N, 0, 0, 0, 0, 0, 0),           mk_out(S_ID, N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[3]  = '{mk_in(N, 0, N, 0, 0, 0, 0, 'hDEAD, 3),      mk_out(S_ID, N, 0, 0, 0, 0, 0, 'hDEAD, 3, 0, 0, 1, 0)};
        // both request, dcache held through two rejects
        tbl[4]  = '{mk_in(LD, 'h200, LD, 'h300, 'h55, 2, 0, 0, 0), mk_out(S_ID, LD, 'h300, 'h55, 2, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{mk_in(LD, 'h200, LD, 'h300, 'h55, 2, 0, 0, 0), mk_out(S_HD, LD, 'h300, 'h55, 2, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[6]  = '{mk_in(LD, 'h200, LD, 'h300, 'h55, 2, 5, 0, 0), mk_out(S_HD, LD, 'h300, 'h55, 2, 0, 5, 0, 0, 0, 0, 0, 0)};
        tbl[7]  = '{mk_in(N, 0, N, 0, 0, 0, 0, 'hBEEF, 5),      mk_out(S_ID, N, 0, 0, 0, 0, 0, 0, 0, 'hBEEF, 5, 1, 0)};
        // starvation: four dcache stores, then icache forced
        for (int i = 8; i < 12; i++)
            tbl[i] = '{mk_in(LD, 'h500, ST, 'h400, 'h11, 3, 7, 0, 0), mk_out(S_ID, ST, 'h400, 'h11, 3, 0, 7, 0, 0, 0, 0, 0, 0)};
        tbl[12] = '{mk_in(LD, 'h500, ST, 'h400, 'h11, 3, 7, 0, 0), mk_out(S_ID, LD, 'h500, 0, 3, 7, 0, 0, 0, 0, 0, 0, 0)};
        tbl[13] = '{mk_in(LD, 'h500, ST, 'h400, 'h11, 3, 0, 0, 0), mk_out(S_ID, ST, 'h400, 'h11, 3, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[14] = '{mk_in(N, 0, N, 0, 0, 0, 0, 0, 0),           mk_out(S_HD, N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
        // store allocates nothing, its tag coming back is spurious
        tbl[15] = '{mk_in(N, 0, ST, 'h600, 'h22, 1, 2, 0, 0),   mk_out(S_ID, ST, 'h600, 'h22, 1, 0, 2, 0, 0, 0, 0, 1, 0)};
        tbl[16] = '{mk_in(N, 0, N, 0, 0, 0, 0, 'h77, 2),        mk_out(S_ID, N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
        tbl[17] = '{mk_in(N, 0, N, 0, 0, 0, 0, 0, 0),           mk_out(S_ID, N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)};
        // tag 4 returned to icache while reissued to dcache
        tbl[18] = '{mk_in(LD, 'h700, N, 0, 0, 0, 4, 0, 0),      mk_out(S_ID, LD, 'h700, 0, 3, 4, 0, 0, 0, 0, 0, 1, 1)};
        tbl[19] = '{mk_in(N, 0, LD, 'h800, 0, 3, 4, 'hCAFE, 4), mk_out(S_ID, LD, 'h800, 0, 3, 0, 4, 'hCAFE, 4, 0, 0, 2, 1)};
        tbl[20] = '{mk_in(N, 0, N, 0, 0, 0, 0, 'hF00D, 4),      mk_out(S_ID, N, 0, 0, 0, 0, 0, 0, 0, 'hF00D, 4, 2, 1)};

        repeat (2) @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 21; i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // build three outstanding loads, then park in HOLD_D
        apply('{mk_in(LD, 'h900, N, 0, 0, 0, 8, 0, 0), mk_out(S_ID, LD, 'h900, 0, 3, 8, 0, 0, 0, 0, 0, 1, 1)}, "ld_tag8");
        apply('{mk_in(LD, 'h904, N, 0, 0, 0, 9, 0, 0), mk_out(S_ID, LD, 'h904, 0, 3, 9, 0, 0, 0, 0, 0, 2, 1)}, "ld_tag9");
        apply('{mk_in(N, 0, LD, 'hA00, 0, 2, 0, 0, 0), mk_out(S_ID, LD, 'hA00, 0, 2, 0, 0, 0, 0, 0, 0, 3, 1)}, "hold_d_a");
        apply('{mk_in(N, 0, LD, 'hA00, 0, 2, 0, 0, 0), mk_out(S_HD, LD, 'hA00, 0, 2, 0, 0, 0, 0, 0, 0, 3, 1)}, "hold_d_b");

        // asynchronous reset mid-cycle with busy inputs
        @(posedge clock);
        #1;
        drive(mk_in(LD, 'hB00, LD, 'hA00, 0, 2, 6, 'h1234, 7));
        #2;
        reset = 1'b0;
        #1;
        a = actual();
        checks++;
        if (a !== '0) begin
            failures++;
            $display("FAIL async_reset_outputs: got %h required 0", a);
        end
        drive(mk_in(N, 0, N, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        reset = 1'b1;

        apply('{mk_in(N, 0, N, 0, 0, 0, 0, 0, 0),      mk_out(S_ID, N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)}, "post_reset");
        apply('{mk_in(N, 0, N, 0, 0, 0, 0, 'h99, 8),   mk_out(S_ID, N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)}, "lost_tag8");
        apply('{mk_in(N, 0, N, 0, 0, 0, 0, 0, 0),      mk_out(S_ID, N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)}, "lost_tag8_flag");

        // accept into an already-valid entry overwrites and flags
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        apply('{mk_in(LD, 'hC00, N, 0, 0, 0, 3, 0, 0),   mk_out(S_ID, LD, 'hC00, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0)}, "ow_first");
        apply('{mk_in(N, 0, LD, 'hD00, 0, 3, 3, 0, 0),   mk_out(S_ID, LD, 'hD00, 0, 3, 0, 3, 0, 0, 0, 0, 1, 0)}, "ow_second");
        apply('{mk_in(N, 0, N, 0, 0, 0, 0, 'hAB, 3),     mk_out(S_ID, N, 0, 0, 0, 0, 0, 0, 0, 'hAB, 3, 1, 1)}, "ow_return");
        apply('{mk_in(N, 0, N, 0, 0, 0, 0, 0, 0),        mk_out(S_ID, N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)}, "ow_drained");

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d entries required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
